// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for the three-requester AXI read arbiter: requester-side AR/R
// vectors plus the single CPU-level AXI read master channel pair.
// The "master" modport is the arbiter's view; "slave" is the environment's view.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
);
   // Requester side (bit/slice 0 = DCache, 1 = uncache, 2 = ICache)
   logic [2:0]          req_arvalid;
   logic [3*ADDR_W-1:0] req_araddr;
   logic [3*LEN_W-1:0]  req_arlen;
   logic [3*3-1:0]      req_arsize;
   logic [2:0]          req_arready;
   logic [2:0]          req_rvalid;
   logic [DATA_W-1:0]   req_rdata;
   logic [1:0]          req_rresp;
   logic                req_rlast;
   logic [2:0]          req_rready;

   // AXI master side
   logic                m_arvalid;
   logic                m_arready;
   logic [ADDR_W-1:0]   m_araddr;
   logic [LEN_W-1:0]    m_arlen;
   logic [2:0]          m_arsize;
   logic [1:0]          m_arburst;
   logic [3:0]          m_arid;
   logic                m_rvalid;
   logic                m_rready;
   logic [DATA_W-1:0]   m_rdata;
   logic [1:0]          m_rresp;
   logic                m_rlast;

   modport master (
      input  req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
             m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
      output req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
             m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
   );

   modport slave (
      output req_arvalid, req_araddr, req_arlen, req_arsize, req_rready,
             m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
      input  req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
             m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, m_rready
   );
endinterface

// File: rtl/axi_rd_arbiter.sv
// AXI read arbiter: shares one AR/R channel pair among DCache refill, the
// uncached data path and ICache refill. One transaction at a time; the winner's
// AR fields are registered, then R beats are routed back to it until RLAST.
// Interface parameters must match the module parameters.
module axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   axi_rd_arbiter_if.master bus,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   state_e            state_q;
   logic [1:0]        owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [2:0]        size_q;
   logic [LEN_W-1:0]  beat_q;
   logic              arvalid_q;
   logic              busy_q;

   logic [1:0]        owner_d;
   logic [2:0]        grant_d;
   logic [2:0]        rvalid_d;
   logic              beat_done;

   // Fixed-priority winner among pending requests: DCache > uncache > ICache.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      owner_d = 2'd0;
      grant_d = 3'b000;
      if (bus.req_arvalid[0]) begin
         owner_d = 2'd0;
         grant_d = 3'b001;
      end else if (bus.req_arvalid[1]) begin
         owner_d = 2'd1;
         grant_d = 3'b010;
      end else if (bus.req_arvalid[2]) begin
         owner_d = 2'd2;
         grant_d = 3'b100;
      end
   end

   // Route the slave's R valid to the current owner only.
   always_comb begin
      rvalid_d = 3'b000;
      if (state_q == DATA) begin
         rvalid_d[owner_q] = bus.m_rvalid;
      end
   end

   // Grant is combinational in IDLE; reset suppresses it in the same cycle.
   assign bus.req_arready = (state_q == IDLE && !rst) ? grant_d : 3'b000;
   assign bus.req_rvalid  = rvalid_d;
   assign bus.req_rdata   = bus.m_rdata;
   assign bus.req_rresp   = bus.m_rresp;
   assign bus.req_rlast   = bus.m_rlast;
   assign bus.m_rready    = (state_q == DATA) ? bus.req_rready[owner_q] : 1'b0;

   assign bus.m_arvalid   = arvalid_q;
   assign bus.m_araddr    = addr_q;
   assign bus.m_arlen     = len_q;
   assign bus.m_arsize    = size_q;
   assign bus.m_arburst   = (len_q != '0) ? 2'b01 : 2'b00;
   assign bus.m_arid      = {2'b00, owner_q};
   assign busy            = busy_q;

   assign beat_done = (state_q == DATA) && bus.m_rvalid && bus.m_rready;

   // Transaction FSM: grant in IDLE, present AR in ADDR, route beats in DATA.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 2'd0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         beat_q    <= '0;
         arvalid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|bus.req_arvalid) begin
                  owner_q   <= owner_d;
                  addr_q    <= bus.req_araddr[owner_d*ADDR_W +: ADDR_W];
                  len_q     <= bus.req_arlen[owner_d*LEN_W +: LEN_W];
                  size_q    <= bus.req_arsize[owner_d*3 +: 3];
                  arvalid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= ADDR;
               end
            end
            ADDR: begin
               if (bus.m_arready) begin
                  arvalid_q <= 1'b0;
                  beat_q    <= '0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (beat_done) begin
                  beat_q <= beat_q + 1'b1;
                  if (bus.m_rlast) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               arvalid_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   // Simulation-only protocol check: the RLAST beat must be beat number arlen.
   proto_err: assert property (@(posedge clk) disable iff (rst)
      (beat_done && bus.m_rlast) |-> (beat_q == len_q));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter. Expected R beats are pushed
// to a scoreboard when the slave stimulus is planned and popped as the DUT
// hands them to the owning requester.
module tb_axi_rd_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic          last;
      logic [1:0]    resp;
   } beat_t;

   logic clk;
   logic rst;
   logic busy;

   int n_assert = 0;
   int n_fail   = 0;
   beat_t sb[$];

   axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench always ends on its own.
   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int r, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [2:0] s);
      bus.req_arvalid[r]          = 1'b1;
      bus.req_araddr[r*AW +: AW]  = a;
      bus.req_arlen[r*LW +: LW]   = l;
      bus.req_arsize[r*3 +: 3]    = s;
   endtask

   task automatic check_ar(input int r, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [2:0] s);
      check("m_arvalid", bus.m_arvalid, 1);
      check("m_araddr",  bus.m_araddr,  a);
      check("m_arlen",   bus.m_arlen,   l);
      check("m_arsize",  bus.m_arsize,  s);
      check("m_arburst", bus.m_arburst, (l != 0) ? 2'b01 : 2'b00);
      check("m_arid",    bus.m_arid,    r);
      check("arready_in_addr", bus.req_arready, 0);
      check("busy_addr", busy, 1);
   endtask

   // Expect requester r to win in the current IDLE cycle, then run the
   // address phase with 'stall' cycles of m_arready low while the requester
   // inputs are scrambled.
   task automatic grant_addr(input int r, input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [2:0] s, input int stall);
      logic [2:0]    sv_v;
      logic [3*AW-1:0] sv_a;
      logic [3*LW-1:0] sv_l;
      logic [8:0]    sv_s;
      settle();
      check("busy_idle", busy, 0);
      check("m_arvalid_idle", bus.m_arvalid, 0);
      check("arready_grant", bus.req_arready, 64'd1 << r);
      clk1();
      bus.req_arvalid[r] = 1'b0;
      sv_v = bus.req_arvalid;
      sv_a = bus.req_araddr;
      sv_l = bus.req_arlen;
      sv_s = bus.req_arsize;
      for (int k = 0; k < stall; k++) begin
         bus.m_arready   = 1'b0;
         bus.req_arvalid = 3'($urandom);
         bus.req_araddr  = {$urandom, $urandom, $urandom};
         bus.req_arlen   = 12'($urandom);
         bus.req_arsize  = 9'($urandom);
         settle();
         check_ar(r, a, l, s);
         clk1();
      end
      bus.req_arvalid = sv_v;
      bus.req_araddr  = sv_a;
      bus.req_arlen   = sv_l;
      bus.req_arsize  = sv_s;
      bus.m_arready   = 1'b1;
      settle();
      check_ar(r, a, l, s);
      clk1();
      bus.m_arready = 1'b0;
   endtask

   // Slave returns len+1 beats to owner r; with 'toggle' the owner's rready
   // alternates 1,0,1,0 while the other requesters hold rready high.
   task automatic data_phase(input int r, input int len, input bit toggle, input logic [1:0] resp);
      logic [DW-1:0] d[$];
      logic [2:0]    rr;
      beat_t         e;
      int            i;
      int            cyc;
      for (int k = 0; k <= len; k++) begin
         d.push_back($urandom);
         sb.push_back('{id: 2'(r), data: d[k], last: (k == len), resp: resp});
      end
      // Slave turnaround cycle: nothing valid yet.
      settle();
      check("rvalid_turnaround", bus.req_rvalid, 0);
      check("arready_data", bus.req_arready, 0);
      clk1();
      i   = 0;
      cyc = 0;
      while (i <= len && cyc < 64) begin
         rr = 3'b111;
         if (toggle && (cyc % 2 == 1)) rr[r] = 1'b0;
         bus.req_rready = rr;
         bus.m_rvalid   = 1'b1;
         bus.m_rdata    = d[i];
         bus.m_rlast    = (i == len);
         bus.m_rresp    = resp;
         settle();
         check("m_rready", bus.m_rready, rr[r]);
         check("req_rvalid", bus.req_rvalid, 64'd1 << r);
         check("arready_data", bus.req_arready, 0);
         check("busy_data", busy, 1);
         if (bus.m_rready) begin
            e = sb.pop_front();
            check("beat_owner", bus.req_rvalid, 64'd1 << e.id);
            check("req_rdata", bus.req_rdata, e.data);
            check("req_rlast", bus.req_rlast, e.last);
            check("req_rresp", bus.req_rresp, e.resp);
            i++;
         end
         cyc++;
         clk1();
      end
      check("beats_done", i, len + 1);
      bus.m_rvalid   = 1'b0;
      bus.m_rlast    = 1'b0;
      bus.req_rready = 3'b000;
      settle();
      check("busy_after_last", busy, 0);
      check("m_arvalid_after", bus.m_arvalid, 0);
      check("req_rvalid_after", bus.req_rvalid, 0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.req_arvalid = '0;
      bus.req_araddr  = '0;
      bus.req_arlen   = '0;
      bus.req_arsize  = '0;
      bus.req_rready  = '0;
      bus.m_arready   = 1'b0;
      bus.m_rvalid    = 1'b0;
      bus.m_rdata     = '0;
      bus.m_rresp     = 2'b00;
      bus.m_rlast     = 1'b0;
      clk1();
      clk1();

      // Reset together with an IDLE request: no grant.
      set_req(0, 32'h0000_1000, 4'd0, 3'd2);
      settle();
      check("rst_arready", bus.req_arready, 0);
      check("rst_busy", busy, 0);
      check("rst_m_arvalid", bus.m_arvalid, 0);
      check("rst_m_rready", bus.m_rready, 0);
      check("rst_req_rvalid", bus.req_rvalid, 0);
      clk1();
      bus.req_arvalid = '0;
      rst = 1'b0;
      settle();
      check("idle_arready", bus.req_arready, 0);
      check("idle_busy", busy, 0);
      check("idle_m_arid", bus.m_arid, 0);
      clk1();

      // Single DCache read, zero-wait slave.
      set_req(0, 32'h1FC0_0040, 4'd3, 3'd2);
      grant_addr(0, 32'h1FC0_0040, 4'd3, 3'd2, 0);
      data_phase(0, 3, 1'b0, 2'b00);
      clk1();

      // All three requesting at once: DCache, uncache, ICache in order.
      set_req(0, 32'h0000_0100, 4'd1, 3'd2);
      set_req(1, 32'hBFD0_0008, 4'd0, 3'd2);
      set_req(2, 32'h0040_0200, 4'd3, 3'd2);
      grant_addr(0, 32'h0000_0100, 4'd1, 3'd2, 0);
      data_phase(0, 1, 1'b0, 2'b00);
      grant_addr(1, 32'hBFD0_0008, 4'd0, 3'd2, 0);
      data_phase(1, 0, 1'b0, 2'b10);
      grant_addr(2, 32'h0040_0200, 4'd3, 3'd2, 0);
      data_phase(2, 3, 1'b0, 2'b11);
      clk1();

      // ICache len=7 with toggling rready; DCache arrives during DATA.
      set_req(2, 32'h0040_1000, 4'd7, 3'd2);
      grant_addr(2, 32'h0040_1000, 4'd7, 3'd2, 0);
      set_req(0, 32'h0000_2000, 4'd1, 3'd2);
      data_phase(2, 7, 1'b1, 2'b00);
      grant_addr(0, 32'h0000_2000, 4'd1, 3'd2, 0);
      data_phase(0, 1, 1'b0, 2'b00);
      clk1();

      // AR stall of five cycles with requester inputs changing meanwhile.
      set_req(1, 32'hBFC0_1234, 4'd2, 3'd1);
      grant_addr(1, 32'hBFC0_1234, 4'd2, 3'd1, 5);
      data_phase(1, 2, 1'b0, 2'b00);
      clk1();

      // Reset on the second beat of a four-beat burst.
      set_req(0, 32'h0000_3000, 4'd3, 3'd2);
      grant_addr(0, 32'h0000_3000, 4'd3, 3'd2, 0);
      clk1();
      bus.m_rvalid   = 1'b1;
      bus.m_rdata    = 32'hCAFE_0000;
      bus.req_rready = 3'b001;
      settle();
      check("mid_rvalid_beat0", bus.req_rvalid, 3'b001);
      clk1();
      bus.m_rdata = 32'hCAFE_0001;
      rst = 1'b1;
      clk1();
      rst = 1'b0;
      settle();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_m_rready", bus.m_rready, 0);
      check("mid_rst_req_rvalid", bus.req_rvalid, 0);
      check("mid_rst_m_arvalid", bus.m_arvalid, 0);
      check("mid_rst_arready", bus.req_arready, 0);
      bus.m_rvalid   = 1'b0;
      bus.req_rready = 3'b000;
      clk1();
      set_req(1, 32'hBFD0_0040, 4'd1, 3'd2);
      grant_addr(1, 32'hBFD0_0040, 4'd1, 3'd2, 0);
      data_phase(1, 1, 1'b0, 2'b00);
      check("sb_empty", sb.size(), 0);
      clk1();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
